// File: rtl/gpr_scoreboard_file.sv
// rtl/gpr_scoreboard_file.sv - integer register file with per-register busy scoreboard and issue stall
// Optional same-cycle write-to-read forwarding is enabled by defining GPR_BYPASS_EN.
module gpr_scoreboard_file #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    output logic [XLEN-1:0]   rs1_data_out,
    output logic [XLEN-1:0]   rs2_data_out,
    output logic              rs1_busy_out,
    output logic              rs2_busy_out,
    input  logic              issue_valid_in,
    input  logic [ADDR_W-1:0] issue_rd_in,
    output logic              stall_out,
    input  logic              write_enable_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]   rd_data_in,
    input  logic              flush_in,
    output logic [ADDR_W:0]   pending_cnt_out
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  ebusy;
    logic [NREGS-1:0]  wr_mask;
    logic [NREGS-1:0]  rsv_mask;
    logic [NREGS-1:0]  byp_mask;
    logic [ADDR_W:0]   cnt_q;
    logic              wr_en;
    logic              reserve;
    logic              inc;
    logic              dec;

    // Gating with reset_in keeps forwarded data off the read ports while reset is held.
    assign wr_en = write_enable_in & (rd_addr_in != '0) & reset_in;

    assign wr_mask  = wr_en ? ({{(NREGS-1){1'b0}}, 1'b1} << rd_addr_in) : '0;
    assign rsv_mask = reserve ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_rd_in) : '0;

`ifdef GPR_BYPASS_EN
    assign byp_mask = wr_mask;
`else
    assign byp_mask = '0;
`endif

    assign ebusy = busy & ~byp_mask;

    assign rs1_busy_out = ebusy[rs1_addr_in];
    assign rs2_busy_out = ebusy[rs2_addr_in];

    assign stall_out = issue_valid_in &
                       (ebusy[rs1_addr_in] | ebusy[rs2_addr_in] | ebusy[issue_rd_in]);

    assign reserve = issue_valid_in & ~stall_out & ~flush_in & (issue_rd_in != '0);

    // A same-register write and reserve nets to zero: the clear is undone by the set.
    assign dec = wr_en & busy[rd_addr_in];
    assign inc = reserve & ~(busy[issue_rd_in] & ~wr_mask[issue_rd_in]);

    always_comb begin
        rs1_data_out = '0;
        rs2_data_out = '0;
        if (rs1_addr_in != '0) begin
            rs1_data_out = regs[rs1_addr_in];
`ifdef GPR_BYPASS_EN
            if (wr_en && (rd_addr_in == rs1_addr_in)) rs1_data_out = rd_data_in;
`endif
        end
        if (rs2_addr_in != '0) begin
            rs2_data_out = regs[rs2_addr_in];
`ifdef GPR_BYPASS_EN
            if (wr_en && (rd_addr_in == rs2_addr_in)) rs2_data_out = rd_data_in;
`endif
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rd_addr_in] <= rd_data_in;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            busy  <= '0;
            cnt_q <= '0;
        end else if (flush_in) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy  <= (busy & ~wr_mask) | rsv_mask;
            cnt_q <= cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        end
    end

    assign pending_cnt_out = cnt_q;

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// tb/tb_gpr_scoreboard_file.sv - directed self-checking bench for gpr_scoreboard_file
module tb_gpr_scoreboard_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        rs1_busy, rs2_busy, issue_valid, stall, we, flush;
    logic [5:0]  pending_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    gpr_scoreboard_file #(.XLEN(32), .ADDR_W(5)) dut (
        .clock_in        (clk),
        .reset_in        (rst_n),
        .rs1_addr_in     (rs1_addr),
        .rs2_addr_in     (rs2_addr),
        .rs1_data_out    (rs1_data),
        .rs2_data_out    (rs2_data),
        .rs1_busy_out    (rs1_busy),
        .rs2_busy_out    (rs2_busy),
        .issue_valid_in  (issue_valid),
        .issue_rd_in     (issue_rd),
        .stall_out       (stall),
        .write_enable_in (we),
        .rd_addr_in      (rd_addr),
        .rd_data_in      (rd_data),
        .flush_in        (flush),
        .pending_cnt_out (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; we = 1'b0; rd_addr = '0;
        rd_data = '0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic reserve(input logic [4:0] r);
        idle();
        issue_valid = 1'b1; issue_rd = r;
        tick();
        idle();
    endtask

    task automatic write(input logic [4:0] r, input logic [31:0] d);
        idle();
        we = 1'b1; rd_addr = r; rd_data = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_held_cnt", {26'd0, pending_cnt}, 32'd0);
        check("rst_held_stall", {31'd0, stall}, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // T1: every address reads zero and idle
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0]; rs2_addr = 5'(31 - a);
            #1;
            check("t1_rs1_data", rs1_data, 32'd0);
            check("t1_rs2_data", rs2_data, 32'd0);
            check("t1_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        end
        check("t1_cnt", {26'd0, pending_cnt}, 32'd0);
        check("t1_stall", {31'd0, stall}, 32'd0);

        // T2: write x5 and attempt x0
        write(5'd5, 32'hDEADBEEF);
        write(5'd0, 32'hFFFFFFFF);
        rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
        check("t2_x5", rs1_data, 32'hDEADBEEF);
        check("t2_x0", rs2_data, 32'd0);
        check("t2_cnt", {26'd0, pending_cnt}, 32'd0);

        // T3: RAW hazard on x3
        reserve(5'd3);
        rs1_addr = 5'd3; #1;
        check("t3_cnt1", {26'd0, pending_cnt}, 32'd1);
        check("t3_busy3", {31'd0, rs1_busy}, 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        check("t3_stall", {31'd0, stall}, 32'd1);
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'h12; #1;
`ifdef GPR_BYPASS_EN
        check("t3_wr_stall", {31'd0, stall}, 32'd0);
        check("t3_wr_fwd", rs1_data, 32'h12);
`else
        check("t3_wr_stall", {31'd0, stall}, 32'd1);
        check("t3_wr_old", rs1_data, 32'd0);
`endif
        tick();
        we = 1'b0; #1;
        check("t3_after_stall", {31'd0, stall}, 32'd0);
        check("t3_after_cnt", {26'd0, pending_cnt}, 32'd0);
        check("t3_after_data", rs1_data, 32'h12);
        idle();

        // T4: WAW with same-cycle write and reserve of x7
        reserve(5'd7);
        check("t4_cnt1", {26'd0, pending_cnt}, 32'd1);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd7; #1;
`ifdef GPR_BYPASS_EN
        check("t4_stall", {31'd0, stall}, 32'd0);
`else
        check("t4_stall", {31'd0, stall}, 32'd1);
`endif
        tick();
        idle();
        rs1_addr = 5'd7; #1;
        check("t4_data", rs1_data, 32'h77);
`ifdef GPR_BYPASS_EN
        check("t4_busy7", {31'd0, rs1_busy}, 32'd1);
        check("t4_cnt", {26'd0, pending_cnt}, 32'd1);
`else
        check("t4_busy7", {31'd0, rs1_busy}, 32'd0);
        check("t4_cnt", {26'd0, pending_cnt}, 32'd0);
`endif
        write(5'd7, 32'h78);
        write(5'd7, 32'h79);
        check("t4_clean_cnt", {26'd0, pending_cnt}, 32'd0);

        // T5: flush drops reservations, keeps same-cycle write
        reserve(5'd1);
        reserve(5'd2);
        reserve(5'd4);
        check("t5_cnt3", {26'd0, pending_cnt}, 32'd3);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
        we = 1'b1; rd_addr = 5'd10; rd_data = 32'hA5;
        rs1_addr = 5'd4; #1;
        check("t5_preflush_stall", {31'd0, stall}, 32'd1);
        rs1_addr = 5'd0; #1;
        check("t5_flush_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        rs1_addr = 5'd6; rs2_addr = 5'd1; #1;
        check("t5_cnt0", {26'd0, pending_cnt}, 32'd0);
        check("t5_busy6_1", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        rs1_addr = 5'd10; #1;
        check("t5_x10", rs1_data, 32'hA5);

        // T6: asynchronous reset between edges
        write(5'd9, 32'h55);
        reserve(5'd11);
        reserve(5'd12);
        reserve(5'd13);
        rs1_addr = 5'd9; #1;
        check("t6_cnt3", {26'd0, pending_cnt}, 32'd3);
        check("t6_x9", rs1_data, 32'h55);
        rst_n = 1'b0; #1;
        check("t6_rst_cnt", {26'd0, pending_cnt}, 32'd0);
        check("t6_rst_x9", rs1_data, 32'd0);
        rs2_addr = 5'd11; issue_valid = 1'b1; issue_rd = 5'd12; #1;
        check("t6_rst_busy", {31'd0, rs2_busy}, 32'd0);
        check("t6_rst_stall", {31'd0, stall}, 32'd0);
        idle();
        rst_n = 1'b1;
        tick();
        rs1_addr = 5'd13; #1;
        check("t6_post_cnt", {26'd0, pending_cnt}, 32'd0);
        check("t6_post_busy", {31'd0, rs1_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
